// File: rtl/cache_fill_fsm.sv
// Cache miss fill initiator: issues WORDS back-to-back word reads,
// steers in-order responses into the data array, pulses tag on last word.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   miss_detected/address miss request, sampled in IDLE only
//   memory_data(_valid)   in-order read responses from memory
//   fsm_busy              fill in progress (cache stalls)
//   mem_enable/mem_wr     read strobe / constant 0
//   memory_address        byte address of the current request
//   write_data_array      write cache_data_out at cache_word_offset
//   write_tag_array       one-cycle tag/valid write on final word
//   cache_word_offset     word index of the current data write
//   cache_data_out        passthrough of memory_data
`timescale 1ns/1ps
module cache_fill_fsm #(
  parameter int ADDR_WIDTH = 16,
  parameter int WORDS      = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     miss_detected,
  input  logic [ADDR_WIDTH-1:0]    miss_address,
  input  logic [15:0]              memory_data,
  input  logic                     memory_data_valid,
  output logic                     fsm_busy,
  output logic                     mem_enable,
  output logic                     mem_wr,
  output logic [ADDR_WIDTH-1:0]    memory_address,
  output logic                     write_data_array,
  output logic                     write_tag_array,
  output logic [$clog2(WORDS)-1:0] cache_word_offset,
  output logic [15:0]              cache_data_out
);

  localparam int OFF = $clog2(WORDS);
  localparam int CW  = OFF + 1;

  localparam logic [ADDR_WIDTH-1:0] BLK_MASK =
    ~ADDR_WIDTH'(2 * WORDS - 1);

  typedef enum logic {IDLE, FETCH} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] base_q, base_d;
  logic [ADDR_WIDTH-1:0] last_q, last_d;
  logic [CW-1:0]         issue_q, issue_d;
  logic [CW-1:0]         recv_q, recv_d;
  logic [ADDR_WIDTH-1:0] issue_addr;
  logic [CW-1:0]         recv_lim;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      base_q  <= '0;
      last_q  <= '0;
      issue_q <= '0;
      recv_q  <= '0;
    end else begin
      state_q <= state_d;
      base_q  <= base_d;
      last_q  <= last_d;
      issue_q <= issue_d;
      recv_q  <= recv_d;
    end
  end

  assign mem_wr         = 1'b0;
  assign cache_data_out = memory_data;
  assign issue_addr     = base_q
                        + ADDR_WIDTH'({issue_q, 1'b0});

  always_comb begin
    state_d           = state_q;
    base_d            = base_q;
    last_d            = last_q;
    issue_d           = issue_q;
    recv_d            = recv_q;
    fsm_busy          = 1'b0;
    mem_enable        = 1'b0;
    write_data_array  = 1'b0;
    write_tag_array   = 1'b0;
    memory_address    = last_q;
    cache_word_offset = recv_q[OFF-1:0];
    recv_lim          = issue_q;

    unique case (state_q)
      IDLE: begin
        if (miss_detected) begin
          base_d  = miss_address & BLK_MASK;
          issue_d = '0;
          recv_d  = '0;
          state_d = FETCH;
        end
      end
      FETCH: begin
        fsm_busy = 1'b1;
        if (issue_q < CW'(WORDS)) begin
          mem_enable     = 1'b1;
          memory_address = issue_addr;
          last_d         = issue_addr;
          issue_d        = issue_q + 1'b1;
        end
        // A zero-latency response may match the request
        // being issued this very cycle.
        recv_lim = issue_q + CW'(mem_enable);
        if (memory_data_valid && (recv_q < recv_lim)) begin
          write_data_array = 1'b1;
          recv_d           = recv_q + 1'b1;
          if (recv_q == CW'(WORDS - 1)) begin
            write_tag_array = 1'b1;
            state_d         = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: doc/cache_fill_fsm.md
Name: cache_fill_fsm

Overview:
Miss-handling initiator that sits between a cache and the byte-addressable, 16-bit word memory.
- On a cache miss it issues one read per word of the missing block, one per cycle, back-to-back.
- It collects the returned words, steers each into the cache data array at the correct word offset, and pulses the tag write on the final word.
- It provides the memory read-request side for both I-cache and D-cache fill paths.

Parameters:
ADDR_WIDTH, 16, byte-address width; bit 0 of every issued address is 0.
WORDS, 8, words per cache block; power of 2, minimum 2; block size is 2*WORDS bytes.

Ports:
clk  input  1  clock; all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
miss_detected  input  1  cache miss request; sampled only in IDLE
miss_address  input  ADDR_WIDTH  byte address of the missing access; sampled with miss_detected
memory_data  input  16  read data returned by memory
memory_data_valid  input  1  memory_data holds the next in-order response
fsm_busy  output  1  fill in progress; the cache stalls while high
mem_enable  output  1  read request strobe to memory
mem_wr  output  1  constant 0; this block never writes memory
memory_address  output  ADDR_WIDTH  byte address of the current read request
write_data_array  output  1  write cache_data_out at cache_word_offset this cycle
write_tag_array  output  1  one-cycle pulse: write tag/valid for the filled block
cache_word_offset  output  log2(WORDS)  word index within the block for the current data write
cache_data_out  output  16  equals memory_data

Behaviour:
- States: IDLE, FETCH.
- Registers: base (block-aligned address), issue_cnt and recv_cnt (each 0..WORDS, log2(WORDS)+1 bits).
- Reset (rst_n low, asynchronous):
  - state=IDLE, issue_cnt=0, recv_cnt=0, base=0.
  - All outputs 0, memory_address=0.
  - Reset mid-fill abandons the fill: no tag write occurs, and late memory responses are ignored.
- IDLE:
  - fsm_busy=0, mem_enable=0, write strobes 0.
  - On a clock edge with miss_detected=1: base = miss_address with low log2(2*WORDS) bits cleared; issue_cnt=0; recv_cnt=0; go to FETCH.
  - memory_data_valid is ignored in IDLE.
- FETCH:
  - fsm_busy=1.
  - Issue side:
    - mem_enable=1 while issue_cnt<WORDS.
    - memory_address = base + 2*issue_cnt; issue_cnt increments each such cycle.
    - Once issue_cnt==WORDS: mem_enable=0 and memory_address holds its last value.
  - Receive side:
    - A response is accepted when memory_data_valid=1 and recv_cnt<issue_cnt.
    - Accepting a response drives write_data_array=1 and cache_word_offset=recv_cnt[log2(WORDS)-1:0] in the same cycle (combinational), then recv_cnt increments.
    - A valid response with recv_cnt==issue_cnt is an unsolicited response: ignore it, no data write.
  - Responses return in issue order; a response may arrive in the same cycle as its own request (zero-latency memory). In that case it is accepted because issue_cnt is compared pre-increment +1, i.e. the condition is recv_cnt < issue_cnt + mem_enable.
  - On acceptance of the response where recv_cnt==WORDS-1: write_tag_array=1 in the same cycle, and the next state is IDLE.
  - fsm_busy therefore falls the cycle after the last data write.
- miss_detected while in FETCH is ignored; the cache re-presents the miss after fsm_busy falls.
- Back-to-back misses: miss_detected high in the first IDLE cycle after a fill starts a new fill immediately.
- Address arithmetic is modulo 2^ADDR_WIDTH. Since the block is aligned, no wrap occurs inside a block.
- Minimum fill latency with zero-latency memory: WORDS cycles in FETCH. Extra memory latency L adds L cycles.

Test Plan:
- Reset: rst_n=0 mid-cycle with no clock edge -> fsm_busy, mem_enable, write_data_array, write_tag_array all 0 immediately; memory_address=0x0000.
- Zero-latency fill: miss_address=0x1236 with WORDS=8 -> memory_address sequence 0x1230, 0x1232 … 0x123E on 8 consecutive cycles; write_data_array=1 on each with offsets 0..7; write_tag_array pulses only with offset 7; fsm_busy high exactly 8 cycles.
- Latency 4: valid delayed 4 cycles -> requests still issued on 8 consecutive cycles; mem_enable drops after the 8th; data writes at offsets 0..7; fsm_busy high 12 cycles; tag pulse on the last write.
- Gaps and spurious inputs: memory_data_valid deasserted for 3 cycles between words 2 and 3, an extra valid after completion, and miss_detected toggling during FETCH -> no extra writes, no restart, offset sequence unchanged, the extra valid is ignored.
- Reset mid-fill: rst_n low after 5 words received, then released, and 3 more valids arrive -> no data or tag writes, state IDLE; the next miss at 0xFFF8 fills 0xFFF0..0xFFFE correctly.
- Back-to-back: miss at 0x0010, then a miss at 0x2000 held high through completion -> the second fill starts the cycle after the first tag pulse and issues 0x2000 first.
